// File: rtl/exponent_hex_pkg.sv
// rtl/exponent_hex_pkg.sv - shared constants for the multi-digit HEX display controller
package exponent_hex_pkg;

    // Register word addresses
    localparam logic [2:0] ADDR_VALUE      = 3'd0;
    localparam logic [2:0] ADDR_CTRL       = 3'd1;
    localparam logic [2:0] ADDR_RAW_LO     = 3'd2;
    localparam logic [2:0] ADDR_RAW_HI     = 3'd3;
    localparam logic [2:0] ADDR_BLINK_MASK = 3'd4;
    localparam logic [2:0] ADDR_STATUS     = 3'd5;

    // CTRL bit positions
    localparam int CTRL_DECODE_BIT   = 0;
    localparam int CTRL_LZ_BIT       = 1;
    localparam int CTRL_BLINK_BIT    = 2;
    localparam int CTRL_DIGIT_EN_LSB = 8;

    // Active-high segment patterns, index 15 in the top slot down to index 0
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    // Active-high pattern for a dark digit
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/hex_seg_decoder.sv
// rtl/hex_seg_decoder.sv - combinational nibble to active-high seven-segment decoder
module hex_seg_decoder
    import exponent_hex_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    assign segments = SEG_TABLE[nibble];

endmodule

// File: rtl/exponent_hex_display.sv
// rtl/exponent_hex_display.sv - multi-digit seven-segment controller with Avalon-MM registers
module exponent_hex_display
    import exponent_hex_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_DIV  = 25_000_000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [2:0]              address,
    input  logic                    chipselect,
    input  logic                    write_n,
    input  logic [31:0]             writedata,
    output logic [31:0]             readdata,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int                      CW       = $clog2(BLINK_DIV);
    localparam logic [CW-1:0]           CNT_LAST = CW'(BLINK_DIV - 1);
    localparam logic [7*NUM_DIGITS-1:0] HEX_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [31:0]             value_q;
    logic                    decode_en;
    logic                    lz_blank;
    logic                    blink_en;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   blink_mask;
    logic [6:0]              raw_q [NUM_DIGITS];
    logic [CW-1:0]           blink_cnt;
    logic                    blink_phase;
    logic [7*NUM_DIGITS-1:0] hex_q;
    logic [7*NUM_DIGITS-1:0] next_hex;

    logic wr_en;
    logic ctrl_wr;
    logic blink_clear;

    assign wr_en   = chipselect && !write_n;
    assign ctrl_wr = wr_en && (address == ADDR_CTRL);

    // A write that turns blinking off also clears the counter on the same edge,
    // so a coincident wrap can never leave the phase set
    assign blink_clear = !blink_en || (ctrl_wr && !writedata[CTRL_BLINK_BIT]);

    // Register file: writes land on the edge where the strobe is sampled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q    <= '0;
            decode_en  <= 1'b1;
            lz_blank   <= 1'b0;
            blink_en   <= 1'b0;
            digit_en   <= '1;
            blink_mask <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                raw_q[i] <= '0;
            end
        end else if (wr_en) begin
            case (address)
                ADDR_VALUE: value_q <= writedata;
                ADDR_CTRL: begin
                    decode_en <= writedata[CTRL_DECODE_BIT];
                    lz_blank  <= writedata[CTRL_LZ_BIT];
                    blink_en  <= writedata[CTRL_BLINK_BIT];
                    digit_en  <= writedata[CTRL_DIGIT_EN_LSB +: NUM_DIGITS];
                end
                ADDR_RAW_LO: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (i < 4) raw_q[i] <= writedata[(i % 4) * 8 +: 7];
                    end
                end
                ADDR_RAW_HI: begin
                    for (int i = 0; i < NUM_DIGITS; i++) begin
                        if (i >= 4) raw_q[i] <= writedata[(i % 4) * 8 +: 7];
                    end
                end
                ADDR_BLINK_MASK: blink_mask <= writedata[NUM_DIGITS-1:0];
                default: ;
            endcase
        end
    end

    // Blink divider: count 0..BLINK_DIV-1, toggle phase on each wrap
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_clear) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == CNT_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= !blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        logic [6:0] dec_seg;
        logic [6:0] src_seg;
        logic [6:0] pat;
        logic       lz_hit;
        logic       dark;

        hex_seg_decoder u_dec (
            .nibble   (value_q[4*g +: 4]),
            .segments (dec_seg)
        );

        // Digit 0 always shows something, even when the whole value is zero
        if (g == 0) begin : g_first
            assign lz_hit = 1'b0;
        end else begin : g_upper
            assign lz_hit = decode_en && lz_blank &&
                            (value_q[4*NUM_DIGITS-1:4*g] == '0);
        end

        assign src_seg = decode_en ? dec_seg : raw_q[g];
        assign dark    = lz_hit || !digit_en[g] ||
                         (blink_en && blink_mask[g] && blink_phase);
        assign pat     = dark ? SEG_BLANK : src_seg;
        assign next_hex[7*g +: 7] = (ACTIVE_LOW != 0) ? ~pat : pat;
    end

    // Output register drives the pins; reset leaves every segment dark
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex_q <= HEX_OFF;
        end else begin
            hex_q <= next_hex;
        end
    end

    assign hex_out = hex_q;

    // Zero-latency read mux; unimplemented and out-of-range bits read 0
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_VALUE: readdata = value_q;
            ADDR_CTRL: begin
                readdata[CTRL_DECODE_BIT]                   = decode_en;
                readdata[CTRL_LZ_BIT]                       = lz_blank;
                readdata[CTRL_BLINK_BIT]                    = blink_en;
                readdata[CTRL_DIGIT_EN_LSB +: NUM_DIGITS]   = digit_en;
            end
            ADDR_RAW_LO: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (i < 4) readdata[(i % 4) * 8 +: 7] = raw_q[i];
                end
            end
            ADDR_RAW_HI: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (i >= 4) readdata[(i % 4) * 8 +: 7] = raw_q[i];
                end
            end
            ADDR_BLINK_MASK: readdata[NUM_DIGITS-1:0] = blink_mask;
            ADDR_STATUS:     readdata[0] = blink_phase;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_exponent_hex_display.sv
// tb/tb_exponent_hex_display.sv - scoreboard bench for exponent_hex_display
module tb_exponent_hex_display;
    import exponent_hex_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [41:0] hex_out;

    exponent_hex_display #(
        .NUM_DIGITS (6),
        .BLINK_DIV  (4),
        .ACTIVE_LOW (1)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .hex_out    (hex_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        bit          is_read;
        logic [41:0] exp;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    bit          finishing = 1'b0;
    logic [41:0] mon_act;

    function automatic logic [41:0] hx(input logic [6:0] d5, d4, d3, d2, d1, d0);
        return ~{d5, d4, d3, d2, d1, d0};
    endfunction

    localparam logic [41:0] ALL_OFF = '1;

    // Monitor: compare every expectation whose cycle has come
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                mon_act = sb[i].is_read ? {10'b0, readdata} : hex_out;
                checks++;
                if (sb[i].due < cyc) begin
                    errors++;
                    $display("FAIL %s: missed its cycle %0d (now %0d)", sb[i].name, sb[i].due, cyc);
                end else if (mon_act !== sb[i].exp) begin
                    errors++;
                    $display("FAIL %s: got %h, required %h", sb[i].name, mon_act, sb[i].exp);
                end
                sb.delete(i);
            end
        end
        if (finishing && sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
            sb.delete();
        end
    end

    task automatic push(input string nm, input bit is_rd, input logic [41:0] e, input int dly);
        exp_t x;
        x.name = nm; x.is_read = is_rd; x.exp = e; x.due = cyc + dly;
        sb.push_back(x);
    endtask

    task automatic exp_hex(input string nm, input logic [41:0] e, input int dly);
        push(nm, 1'b0, e, dly);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input string nm, input logic [2:0] a, input logic [31:0] e);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        push(nm, 1'b1, {10'b0, e}, 0);
        @(posedge clk); #1;
        chipselect = 1'b0;
    endtask

    logic [41:0] zeros_pat;
    logic [41:0] lit_pat;
    logic [41:0] blink_pat;
    logic [11:0] phase_seq;
    logic [11:0] dark_seq;

    initial begin
        zeros_pat = hx(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
        lit_pat   = hx(7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F);
        blink_pat = hx(7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h00, 7'h00);
        phase_seq = 12'b0000_1111_0000;
        dark_seq  = 12'b0001_1110_0000;

        // Reset and release
        repeat (2) @(posedge clk); #1;
        exp_hex("reset_hold", ALL_OFF, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_hex("release_zero", zeros_pat, 1);
        rd("ctrl_reset", ADDR_CTRL, 32'h0000_3F01);
        @(posedge clk); #1;

        // Decode; read during write returns old value; two-edge latency
        address = ADDR_VALUE; writedata = 32'h00A5_3C19; chipselect = 1'b1; write_n = 1'b0;
        push("read_during_write", 1'b1, 42'h0, 0);
        @(posedge clk); #1;
        chipselect = 1'b0; write_n = 1'b1;
        exp_hex("value_one_edge", zeros_pat, 0);
        exp_hex("value_two_edges", hx(7'h77, 7'h6D, 7'h4F, 7'h39, 7'h06, 7'h6F), 1);
        rd("value_readback", ADDR_VALUE, 32'h00A5_3C19);

        // Leading-zero blanking
        wr(ADDR_CTRL, 32'h0000_3F03);
        wr(ADDR_VALUE, 32'h0000_0030);
        exp_hex("lz_30", hx(7'h00, 7'h00, 7'h00, 7'h00, 7'h4F, 7'h3F), 1);
        wr(ADDR_VALUE, 32'h0);
        exp_hex("lz_zero", hx(7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h3F), 1);

        // Raw mode, digit enables, ignored bits
        wr(ADDR_CTRL, 32'h0000_3F00);
        wr(ADDR_RAW_LO, 32'h0049_7F01);
        exp_hex("raw_lo", hx(7'h00, 7'h00, 7'h00, 7'h49, 7'h7F, 7'h01), 1);
        wr(ADDR_CTRL, 32'h0000_3500);
        exp_hex("digit_en", hx(7'h00, 7'h00, 7'h00, 7'h49, 7'h00, 7'h01), 1);
        rd("raw_lo_read", ADDR_RAW_LO, 32'h0049_7F01);
        wr(ADDR_RAW_HI, 32'hFFFF_FFFF);
        exp_hex("raw_hi", hx(7'h7F, 7'h7F, 7'h00, 7'h49, 7'h00, 7'h01), 1);
        rd("raw_hi_read", ADDR_RAW_HI, 32'h0000_7F7F);
        wr(ADDR_CTRL, 32'hFFFF_FF00);
        rd("ctrl_masked", ADDR_CTRL, 32'h0000_3F00);
        wr(3'd7, 32'hFFFF_FFFF);
        rd("addr7_zero", 3'd7, 32'h0);
        rd("addr6_zero", 3'd6, 32'h0);
        wr(ADDR_RAW_HI, 32'h0);

        // Blinking
        wr(ADDR_CTRL, 32'h0000_3F01);
        wr(ADDR_VALUE, 32'h0054_3210);
        wr(ADDR_BLINK_MASK, 32'hFFFF_FFFF);
        rd("mask_masked", ADDR_BLINK_MASK, 32'h0000_003F);
        wr(ADDR_BLINK_MASK, 32'h3);
        wr(ADDR_CTRL, 32'h0000_3F05);
        for (int t = 0; t < 12; t++) begin
            exp_hex($sformatf("blink_hex_t%0d", t), dark_seq[t] ? blink_pat : lit_pat, 0);
            rd($sformatf("blink_phase_t%0d", t), ADDR_STATUS, {31'b0, phase_seq[t]});
        end
        // Clearing blink_en on a 0->1 wrap edge keeps phase 0
        repeat (7) @(posedge clk); #1;
        wr(ADDR_CTRL, 32'h0000_3F01);
        exp_hex("clear_wrap_hex1", lit_pat, 1);
        exp_hex("clear_wrap_hex2", lit_pat, 2);
        rd("clear_wrap_phase", ADDR_STATUS, 32'h0);
        rd("clear_wrap_phase2", ADDR_STATUS, 32'h0);

        // Asynchronous reset with phase 1
        wr(ADDR_CTRL, 32'h0000_3F05);
        repeat (5) @(posedge clk); #1;
        exp_hex("pre_reset_dark", blink_pat, 0);
        rd("pre_reset_phase", ADDR_STATUS, 32'h1);
        reset_n = 1'b0;
        exp_hex("reset_async", ALL_OFF, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_hex("post_reset_zero", zeros_pat, 1);
        rd("post_reset_phase", ADDR_STATUS, 32'h0);
        rd("post_reset_mask", ADDR_BLINK_MASK, 32'h0);
        rd("post_reset_ctrl", ADDR_CTRL, 32'h0000_3F01);

        repeat (3) @(posedge clk); #1;
        finishing = 1'b1;
        @(negedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
